instr_mem_bank: RTL and testbench

INSTR_MEM_BANK -- requirements
Module: instr_mem_bank

---
 rtl/instr_mem_bank_if.sv | 31 +++
 rtl/instr_mem_bank.sv | 166 ++++++++++++++++
 tb/tb_instr_mem_bank.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_mem_bank_if.sv
// Bus bundle for instr_mem_bank: host read/write port, boot-load stream and status.
interface instr_mem_bank_if #(
    parameter int WIDTH    = 32,
    parameter int ADDRSIZE = 12
);
    logic                  req;
    logic                  wr;
    logic [WIDTH/8-1:0]    byteEn;
    logic [ADDRSIZE-1:0]   address;
    logic [WIDTH-1:0]      dataIn;
    logic [WIDTH-1:0]      dataOut;
    logic                  dataValid;
    logic                  loadStart;
    logic                  loadValid;
    logic                  loadLast;
    logic [WIDTH-1:0]      loadData;
    logic                  busy;
    logic                  loadDone;

    modport master (
        output req, wr, byteEn, address, dataIn,
        output loadStart, loadValid, loadLast, loadData,
        input  dataOut, dataValid, busy, loadDone
    );

    modport slave (
        input  req, wr, byteEn, address, dataIn,
        input  loadStart, loadValid, loadLast, loadData,
        output dataOut, dataValid, busy, loadDone
    );
endinterface

// File: rtl/instr_mem_bank.sv
// Instruction memory with byte-enable host port and a sequential boot-load engine.
// Optional macro INMEM_OUTREG_EN adds a second read output register (latency 2).
module instr_mem_bank #(
    parameter int WIDTH    = 32,
    parameter int ADDRSIZE = 12
) (
    input  logic               clk,
    input  logic               reset,
    instr_mem_bank_if.slave    bus
);
    localparam int NBYTES  = WIDTH / 8;
    localparam int MEMSIZE = 1 << ADDRSIZE;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        LOAD = 1'b1
    } state_t;

    state_t                state_r;
    logic [ADDRSIZE-1:0]   counter_r;
    logic                  busy_r;
    logic                  load_done_r;
    logic [WIDTH-1:0]      data_out_r;
    logic                  data_valid_r;
    logic [WIDTH-1:0]      mem_r [MEMSIZE];

    logic                  host_rd_s;
    logic                  host_wr_s;
    logic                  load_wr_s;
    logic                  load_exit_s;
    logic [ADDRSIZE-1:0]   wr_addr_s;
    logic [WIDTH-1:0]      wr_data_s;
    logic [NBYTES-1:0]     wr_be_s;

    // Access qualification: host port only in IDLE, load stream only in LOAD, nothing under reset.
    always_comb begin
        host_rd_s   = 1'b0;
        host_wr_s   = 1'b0;
        load_wr_s   = 1'b0;
        load_exit_s = 1'b0;
        if (!reset && (state_r == IDLE) && bus.req) begin
            host_rd_s = !bus.wr;
            host_wr_s = bus.wr;
        end else begin
            host_rd_s = 1'b0;
            host_wr_s = 1'b0;
        end
        if (!reset && (state_r == LOAD) && bus.loadValid) begin
            load_wr_s   = 1'b1;
            load_exit_s = bus.loadLast || (counter_r == {ADDRSIZE{1'b1}});
        end else begin
            load_wr_s   = 1'b0;
            load_exit_s = 1'b0;
        end
    end

    // Single write-port mux; load words always write every byte.
    always_comb begin
        wr_addr_s = {ADDRSIZE{1'b0}};
        wr_data_s = {WIDTH{1'b0}};
        wr_be_s   = {NBYTES{1'b0}};
        if (load_wr_s) begin
            wr_addr_s = counter_r;
            wr_data_s = bus.loadData;
            wr_be_s   = {NBYTES{1'b1}};
        end else if (host_wr_s) begin
            wr_addr_s = bus.address;
            wr_data_s = bus.dataIn;
            wr_be_s   = bus.byteEn;
        end else begin
            wr_be_s   = {NBYTES{1'b0}};
        end
    end

    // Storage array: no reset so contents survive a reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NBYTES; i++) begin
            if (wr_be_s[i]) begin
                mem_r[wr_addr_s][8*i +: 8] <= wr_data_s[8*i +: 8];
            end
        end
    end

    // Boot-load state machine; the counter stops at the last word instead of wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            counter_r   <= {ADDRSIZE{1'b0}};
            busy_r      <= 1'b0;
            load_done_r <= 1'b0;
        end else begin
            load_done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.loadStart) begin
                        state_r   <= LOAD;
                        counter_r <= {ADDRSIZE{1'b0}};
                        busy_r    <= 1'b1;
                    end else begin
                        state_r   <= IDLE;
                        busy_r    <= 1'b0;
                    end
                end
                LOAD: begin
                    if (load_exit_s) begin
                        state_r     <= IDLE;
                        busy_r      <= 1'b0;
                        load_done_r <= 1'b1;
                    end else if (load_wr_s) begin
                        counter_r <= counter_r + {{(ADDRSIZE-1){1'b0}}, 1'b1};
                    end else begin
                        busy_r    <= 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // First read stage: data held when no read completes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out_r   <= {WIDTH{1'b0}};
            data_valid_r <= 1'b0;
        end else begin
            data_valid_r <= host_rd_s;
            if (host_rd_s) begin
                data_out_r <= mem_r[bus.address];
            end else begin
                data_out_r <= data_out_r;
            end
        end
    end

`ifdef INMEM_OUTREG_EN
    logic [WIDTH-1:0] data_out2_r;
    logic             data_valid2_r;

    // Extra output stage, still one result per cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out2_r   <= {WIDTH{1'b0}};
            data_valid2_r <= 1'b0;
        end else begin
            data_valid2_r <= data_valid_r;
            if (data_valid_r) begin
                data_out2_r <= data_out_r;
            end else begin
                data_out2_r <= data_out2_r;
            end
        end
    end

    assign bus.dataOut   = data_out2_r;
    assign bus.dataValid = data_valid2_r;
`else
    assign bus.dataOut   = data_out_r;
    assign bus.dataValid = data_valid_r;
`endif

    assign bus.busy     = busy_r;
    assign bus.loadDone = load_done_r;
endmodule

// File: tb/tb_instr_mem_bank.sv
// Self-checking bench for instr_mem_bank: table-driven host ops plus load/reset sequences,
// read results checked through a cycle-stamped scoreboard.
module tb_instr_mem_bank;
    localparam int WIDTH    = 32;
    localparam int ADDRSIZE = 4;
`ifdef INMEM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        logic        wr;
        logic [3:0]  be;
        logic [3:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        int          due;
    } sb_t;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    int   cyc;
    int   done_cnt;
    sb_t  sb[$];
    vec_t tbl[14];

    instr_mem_bank_if #(.WIDTH(WIDTH), .ADDRSIZE(ADDRSIZE)) bus ();

    instr_mem_bank #(.WIDTH(WIDTH), .ADDRSIZE(ADDRSIZE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every dataValid must match the oldest expected read, on its due cycle.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.loadDone === 1'b1) begin
                done_cnt++;
                chk("busy_at_done", bus.busy, 32'd0);
            end
            if (bus.dataValid === 1'b1) begin
                chk("valid_has_expect", (sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    sb_t t;
                    t = sb.pop_front();
                    chk("read_data", bus.dataOut, t.data);
                    chk("read_latency", cyc, t.due);
                end
            end
        end
    end

    task automatic clear_inputs();
        bus.req       = 1'b0;
        bus.wr        = 1'b0;
        bus.loadStart = 1'b0;
        bus.loadValid = 1'b0;
        bus.loadLast  = 1'b0;
    endtask

    task automatic idle();
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic host_op(input logic w, input logic [3:0] be, input logic [3:0] a,
                           input logic [31:0] d, input logic [31:0] e);
        sb_t t;
        @(negedge clk);
        clear_inputs();
        bus.req     = 1'b1;
        bus.wr      = w;
        bus.byteEn  = be;
        bus.address = a;
        bus.dataIn  = d;
        if (!w) begin
            t.data = e;
            t.due  = cyc + LAT;
            sb.push_back(t);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        idle();
        while (sb.size() != 0 && n < 8) begin
            idle();
            n++;
        end
        chk("drain_empty", sb.size(), 32'd0);
        idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        total    = 0;
        bad      = 0;
        done_cnt = 0;
        tbl[0]  = '{1'b1, 4'hF, 4'd5, 32'hAABBCCDD, 32'h0};
        tbl[1]  = '{1'b1, 4'h1, 4'd5, 32'h00000099, 32'h0};
        tbl[2]  = '{1'b0, 4'h0, 4'd5, 32'h0,        32'hAABBCC99};
        tbl[3]  = '{1'b1, 4'hF, 4'd6, 32'h12345678, 32'h0};
        tbl[4]  = '{1'b1, 4'h0, 4'd6, 32'hFFFFFFFF, 32'h0};
        tbl[5]  = '{1'b0, 4'h0, 4'd6, 32'h0,        32'h12345678};
        tbl[6]  = '{1'b1, 4'hF, 4'd7, 32'h00000000, 32'h0};
        tbl[7]  = '{1'b1, 4'hA, 4'd7, 32'hFFFFFFFF, 32'h0};
        tbl[8]  = '{1'b0, 4'h0, 4'd7, 32'h0,        32'hFF00FF00};
        tbl[9]  = '{1'b1, 4'hF, 4'd8, 32'hCAFEBABE, 32'h0};
        tbl[10] = '{1'b0, 4'h0, 4'd8, 32'h0,        32'hCAFEBABE};
        tbl[11] = '{1'b1, 4'hF, 4'd9, 32'h09090909, 32'h0};
        tbl[12] = '{1'b0, 4'h0, 4'd2, 32'h0,        32'h33333333};
        tbl[13] = '{1'b0, 4'h0, 4'd9, 32'h0,        32'h09090909};

        reset       = 1'b1;
        clear_inputs();
        bus.byteEn  = 4'h0;
        bus.address = 4'd0;
        bus.dataIn  = 32'h0;
        bus.loadData = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_busy",      bus.busy,      32'd0);
        chk("rst_valid",     bus.dataValid, 32'd0);
        chk("rst_dataout",   bus.dataOut,   32'd0);
        chk("rst_loaddone",  bus.loadDone,  32'd0);
        reset = 1'b0;

        // 4-word boot load; stray reads and a repeated loadStart during LOAD must be ignored.
        @(negedge clk);
        bus.loadStart = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("load4_busy", bus.busy, 32'd1);
            w = 32'h11111111 * (i + 1);
            bus.loadStart = (i == 1);
            bus.loadValid = 1'b1;
            bus.loadData  = w;
            bus.loadLast  = (i == 3);
            bus.req       = (i < 2);
            bus.wr        = 1'b0;
            bus.address   = i[3:0];
        end
        idle();
        chk("load4_exit_busy", bus.busy,     32'd0);
        chk("load4_done",      bus.loadDone, 32'd1);
        idle();
        chk("load4_done_once", bus.loadDone, 32'd0);
        for (int i = 0; i < 4; i++) begin
            w = 32'h11111111 * (i + 1);
            host_op(1'b0, 4'h0, i[3:0], 32'h0, w);
        end
        drain();

        for (int i = 0; i < 14; i++) begin
            host_op(tbl[i].wr, tbl[i].be, tbl[i].addr, tbl[i].data, tbl[i].exp);
        end
        drain();

        // Short load with a host write attempted while busy.
        @(negedge clk);
        bus.loadStart = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bus.loadStart = 1'b0;
            bus.loadValid = 1'b1;
            bus.loadData  = 32'hC0000000 + i;
            bus.loadLast  = (i == 1);
            bus.req       = (i == 0);
            bus.wr        = 1'b1;
            bus.byteEn    = 4'hF;
            bus.address   = 4'd9;
            bus.dataIn    = 32'hDEADBEEF;
        end
        idle();
        host_op(1'b0, 4'h0, 4'd9, 32'h0, 32'h09090909);
        host_op(1'b0, 4'h0, 4'd0, 32'h0, 32'hC0000000);
        host_op(1'b0, 4'h0, 4'd1, 32'h0, 32'hC0000001);
        drain();

        // Asynchronous reset in the middle of a load after three words.
        @(negedge clk);
        bus.loadStart = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.loadStart = 1'b0;
            bus.loadValid = 1'b1;
            bus.loadData  = 32'hB0000000 + i;
            bus.loadLast  = 1'b0;
        end
        @(negedge clk);
        bus.loadData = 32'hB0000003;
        #2 reset = 1'b1;
        #1;
        chk("arst_busy",    bus.busy,      32'd0);
        chk("arst_valid",   bus.dataValid, 32'd0);
        chk("arst_dataout", bus.dataOut,   32'd0);
        chk("arst_done",    bus.loadDone,  32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        clear_inputs();
        host_op(1'b0, 4'h0, 4'd0, 32'h0, 32'hB0000000);
        host_op(1'b0, 4'h0, 4'd1, 32'h0, 32'hB0000001);
        host_op(1'b0, 4'h0, 4'd2, 32'h0, 32'hB0000002);
        host_op(1'b0, 4'h0, 4'd3, 32'h0, 32'h44444444);
        drain();

        // Full-depth load with no loadLast: exit forced after word 16, word 17 dropped.
        @(negedge clk);
        bus.loadStart = 1'b1;
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            chk("full_busy", bus.busy, (i < 16) ? 32'd1 : 32'd0);
            if (i == 16) chk("full_done", bus.loadDone, 32'd1);
            bus.loadStart = 1'b0;
            bus.loadValid = 1'b1;
            bus.loadData  = 32'hA0000000 + i;
            bus.loadLast  = 1'b0;
        end
        idle();
        chk("full_no_restart", bus.busy, 32'd0);
        host_op(1'b0, 4'h0, 4'd0,  32'h0, 32'hA0000000);
        host_op(1'b0, 4'h0, 4'd7,  32'h0, 32'hA0000007);
        host_op(1'b0, 4'h0, 4'd15, 32'h0, 32'hA000000F);
        drain();

        chk("load_done_count", done_cnt, 32'd3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
